// File: rtl/i2c_sched_pkg.sv
// Shared definitions for the I2C write scheduler: state encoding, timer width
// and default bus widths.
package i2c_sched_pkg;

  localparam int TIMER_W    = 8;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_COMPLETE  = 3'd4,
    S_ABORT     = 3'd5
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping to the lowest index. Returns one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Two passes: indices from the pointer upward first, then the wrapped part.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req[i] && (i >= int'(ptr))) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req[i]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
    if (grant_valid) grant_oh[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/i2c_write_scheduler.sv
// Round-robin scheduler sharing one I2C write master between NUM_REQ clients.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   S_IDLE      | no transaction; arbitrate and latch winner's addr/data
//   S_LAUNCH    | winner latched; m_start is issued on leaving this state
//   S_WAIT_BUSY | waiting for the master to raise m_busy
//   S_WAIT_DONE | waiting for m_busy low with m_valid high
//   S_COMPLETE  | done pulse to the winner, grant already dropped
//   S_ABORT     | err pulse after a wait-state timeout, grant already dropped
module i2c_write_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      sched_busy,
  output logic                      m_start,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_data,
  input  logic                      m_busy,
  input  logic                      m_valid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TIMER_W-1:0] TMO = TIMER_W'(TIMEOUT);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, winner_q, arb_idx;
  logic [NUM_REQ-1:0] arb_oh;
  logic               arb_valid;
  logic [TIMER_W-1:0] timer_q;
  logic               timed_out;

  assign timed_out = (timer_q == TMO);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req         (req),
    .ptr         (rr_ptr_q),
    .grant_oh    (arb_oh),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and the pulse/status outputs decoded from state.
  always_comb begin
    state_d    = state_q;
    done       = '0;
    err        = 1'b0;
    sched_busy = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:      if (arb_valid) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (m_busy)         state_d = S_WAIT_DONE;
        else if (timed_out) state_d = S_ABORT;
      end
      S_WAIT_DONE: begin
        if (!m_busy && m_valid) state_d = S_COMPLETE;
        else if (timed_out)     state_d = S_ABORT;
      end
      S_COMPLETE: begin
        done[winner_q] = 1'b1;
        state_d        = S_IDLE;
      end
      S_ABORT: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Grant/payload capture, launch pulse, wait timer and round-robin pointer.
  // The grant drops on the edge that enters COMPLETE/ABORT so it is already
  // low during the done/err pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt      <= '0;
      m_addr   <= '0;
      m_data   <= '0;
      m_start  <= 1'b0;
      timer_q  <= '0;
      rr_ptr_q <= '0;
      winner_q <= '0;
    end else begin
      m_start <= (state_q == S_LAUNCH);
      case (state_q)
        S_IDLE: begin
          if (arb_valid) begin
            gnt      <= arb_oh;
            winner_q <= arb_idx;
            m_addr   <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
            m_data   <= req_data[int'(arb_idx)*DATA_W +: DATA_W];
          end
        end
        S_LAUNCH: timer_q <= '0;
        S_WAIT_BUSY, S_WAIT_DONE: begin
          if (state_d != state_q)  timer_q <= '0;
          else if (timer_q != '1)  timer_q <= timer_q + 1'b1;
        end
        default: ;
      endcase
      if (state_d == S_COMPLETE || state_d == S_ABORT) begin
        gnt      <= '0;
        rr_ptr_q <= (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_write_scheduler.sv
// Directed bench for i2c_write_scheduler: a table of successful transactions
// followed by hand-written timeout, async-reset and input-stability sequences.
module tb_i2c_write_scheduler;

  localparam int NR  = 4;
  localparam int AW  = 7;
  localparam int DW  = 8;
  localparam int TMO = 255;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   gnt, done;
  logic            err, sched_busy, m_start;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic            m_busy, m_valid;

  int n_cmp = 0;
  int n_bad = 0;

  i2c_write_scheduler #(.NUM_REQ(NR), .TIMEOUT(TMO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .sched_busy(sched_busy), .m_start(m_start),
    .m_addr(m_addr), .m_data(m_data), .m_busy(m_busy), .m_valid(m_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] apk;
    logic [NR*DW-1:0] dpk;
    logic [NR-1:0]    exp_gnt;
    logic [AW-1:0]    exp_addr;
    logic [DW-1:0]    exp_data;
    int               busy_cyc;
  } vec_t;

  vec_t vecs[9];

  // Client i at slot i: pack A = addr 50..53 / data A5,B6,C7,D8;
  // pack B = addr 4F,3E,2D,1C / data 44,33,22,11.
  localparam logic [NR*AW-1:0] APK_A = {7'h53, 7'h52, 7'h51, 7'h50};
  localparam logic [NR*DW-1:0] DPK_A = {8'hD8, 8'hC7, 8'hB6, 8'hA5};
  localparam logic [NR*AW-1:0] APK_B = {7'h1C, 7'h2D, 7'h3E, 7'h4F};
  localparam logic [NR*DW-1:0] DPK_B = {8'h11, 8'h22, 8'h33, 8'h44};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered at a negedge with the scheduler idle. Master asserts busy right
  // after m_start, holds it busy_cyc cycles, then drops busy with valid high.
  task automatic run_txn(input logic [NR-1:0] r, input logic [NR*AW-1:0] apk,
                         input logic [NR*DW-1:0] dpk, input logic [NR-1:0] eg,
                         input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                         input int busy_cyc, input bit disturb);
    req = r; req_addr = apk; req_data = dpk;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(eg));
    check("m_addr", 32'(m_addr), 32'(ea));
    check("m_data", 32'(m_data), 32'(ed));
    check("m_start_pre", 32'(m_start), 32'd0);
    check("sched_busy", 32'(sched_busy), 32'd1);
    @(negedge clk);
    check("m_start_pulse", 32'(m_start), 32'd1);
    m_busy = 1'b1;
    for (int i = 0; i < busy_cyc; i++) begin
      @(negedge clk);
      if (i == 0) check("m_start_post", 32'(m_start), 32'd0);
      if (disturb && i == busy_cyc / 2) begin
        req = '0; req_data = ~dpk; req_addr = ~apk;
      end
    end
    check("no_early_done_err", 32'({done, err}), 32'd0);
    m_busy = 1'b0; m_valid = 1'b1;
    @(negedge clk);
    check("done", 32'(done), 32'(eg));
    check("gnt_at_done", 32'(gnt), 32'd0);
    check("err_at_done", 32'(err), 32'd0);
    check("m_addr_hold", 32'(m_addr), 32'(ea));
    check("m_data_hold", 32'(m_data), 32'(ed));
    m_valid = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(sched_busy), 32'd0);
  endtask

  initial begin
    int cnt;
    bit saw_done;

    vecs[0] = '{4'b1011, APK_A, DPK_A, 4'b0001, 7'h50, 8'hA5, 20};
    vecs[1] = '{4'b1011, APK_A, DPK_A, 4'b0010, 7'h51, 8'hB6, 3};
    vecs[2] = '{4'b1011, APK_A, DPK_A, 4'b1000, 7'h53, 8'hD8, 1};
    vecs[3] = '{4'b1011, APK_A, DPK_A, 4'b0001, 7'h50, 8'hA5, 5};
    vecs[4] = '{4'b1011, APK_A, DPK_A, 4'b0010, 7'h51, 8'hB6, 2};
    vecs[5] = '{4'b0001, APK_A, DPK_A, 4'b0001, 7'h50, 8'hA5, 20};
    vecs[6] = '{4'b0110, APK_B, DPK_B, 4'b0010, 7'h3E, 8'h33, 4};
    vecs[7] = '{4'b1100, APK_B, DPK_B, 4'b0100, 7'h2D, 8'h22, 7};
    vecs[8] = '{4'b1111, APK_B, DPK_B, 4'b1000, 7'h1C, 8'h11, 1};

    reset = 1'b0; req = '0; req_addr = '0; req_data = '0; m_busy = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_outs", 32'({done, err, sched_busy, m_start}), 32'd0);
    check("rst_addr_data", 32'({m_addr, m_data}), 32'd0);
    reset = 1'b1;

    // Pointer 0 at start: 0,1,3,0,1 for 1011, then 0,1,2,3 for the rest.
    for (int v = 0; v < 9; v++)
      run_txn(vecs[v].req, vecs[v].apk, vecs[v].dpk, vecs[v].exp_gnt,
              vecs[v].exp_addr, vecs[v].exp_data, vecs[v].busy_cyc, 1'b0);

    // Busy timeout: master never busy. Pointer is 0, client 0 wins.
    req = 4'b0011; req_addr = APK_A; req_data = DPK_A;
    @(negedge clk);
    check("bto_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    check("bto_m_start", 32'(m_start), 32'd1);
    cnt = 0; saw_done = 1'b0;
    while (cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (done != '0) saw_done = 1'b1;
      if (err) break;
    end
    check("bto_err_latency", 32'(cnt), 32'(TMO + 1));
    check("bto_gnt_clear", 32'(gnt), 32'd0);
    check("bto_no_done", 32'(saw_done), 32'd0);
    @(negedge clk);
    check("bto_err_one_cycle", 32'(err), 32'd0);
    // Pointer moved past client 0, so client 1 is next.
    run_txn(4'b0011, APK_A, DPK_A, 4'b0010, 7'h51, 8'hB6, 2, 1'b0);

    // Done timeout: busy stuck high. Pointer 2.
    req = 4'b0100;
    @(negedge clk);
    check("dto_gnt", 32'(gnt), 32'b0100);
    @(negedge clk);
    m_busy = 1'b1;
    cnt = 0; saw_done = 1'b0;
    while (cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (done != '0) saw_done = 1'b1;
      if (err) break;
    end
    // One cycle in WAIT_BUSY, then TIMEOUT+1 cycles in WAIT_DONE (timer 0..TIMEOUT).
    check("dto_err_latency", 32'(cnt), 32'(TMO + 2));
    check("dto_gnt_clear", 32'(gnt), 32'd0);
    check("dto_no_done", 32'(saw_done), 32'd0);
    m_busy = 1'b0;
    @(negedge clk);
    check("dto_idle", 32'({err, sched_busy}), 32'd0);

    // Async reset during WAIT_DONE. Pointer 3, client 3 wins.
    req = 4'b1000; req_addr = APK_B; req_data = DPK_B;
    @(negedge clk);
    check("rst_mid_gnt", 32'(gnt), 32'b1000);
    @(negedge clk);
    m_busy = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_gnt_drop", 32'(gnt), 32'd0);
    check("rst_mid_outs", 32'({done, err, sched_busy, m_start}), 32'd0);
    check("rst_mid_addr_data", 32'({m_addr, m_data}), 32'd0);
    @(negedge clk);
    m_busy = 1'b0;
    reset = 1'b1;
    run_txn(4'b1000, APK_B, DPK_B, 4'b1000, 7'h1C, 8'h11, 6, 1'b0);

    // Input stability: req dropped and addr/data changed mid WAIT_DONE.
    run_txn(4'b0001, APK_B, DPK_B, 4'b0001, 7'h4F, 8'h44, 8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
